// File: rtl/mic_cfg_pkg.sv
// mic_cfg_pkg: shared types, default widths and channel-search helper for the mic-array config scheduler.
package mic_cfg_pkg;
    localparam int MIC_N_CH   = 16;
    localparam int MIC_CH_W   = 4;
    localparam int MIC_ADDR_W = 8;
    localparam int MIC_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        NEXT,
        DONE
    } state_t;

    // Returns {found, index} of the lowest set bit strictly above base, or of any bit when from_start.
    function automatic logic [MIC_CH_W:0] next_set_above(
        input logic [MIC_N_CH-1:0] mask,
        input logic [MIC_CH_W-1:0] base,
        input logic                from_start
    );
        logic [MIC_CH_W:0] r;
        r = '0;
        for (int i = MIC_N_CH - 1; i >= 0; i--)
            if (mask[i] && (from_start || i > int'(base)))
                r = {1'b1, MIC_CH_W'(i)};
        return r;
    endfunction
endpackage

// File: rtl/mic_cfg_prio_enc.sv
// mic_cfg_prio_enc: finds the lowest set mask bit above base (or the lowest overall when from_start).
module mic_cfg_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] base,
    input  logic         from_start,
    output logic         found,
    output logic [W-1:0] idx
);
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (mask[i] && (from_start || i > int'(base))) begin
                found = 1'b1;
                idx   = W'(i);
            end
    end
endmodule

// File: rtl/mic_array_cfg_scheduler.sv
// mic_array_cfg_scheduler: issues register writes to the mic-array control engines one channel at a time,
// waiting out each engine's busy window and skipping engines that stall past TIMEOUT cycles.
module mic_array_cfg_scheduler
    import mic_cfg_pkg::*;
#(
    parameter int N_CH    = MIC_N_CH,
    parameter int CH_W    = MIC_CH_W,
    parameter int ADDR_W  = MIC_ADDR_W,
    parameter int DATA_W  = MIC_DATA_W,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_bcast,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [N_CH-1:0]   ch_enable,
    output logic [N_CH-1:0]   ch_start,
    output logic [ADDR_W-1:0] ch_addr,
    output logic [DATA_W-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_busy,
    output logic              done,
    output logic              sched_busy,
    output logic              err_timeout,
    output logic [CH_W-1:0]   err_ch,
    input  logic              clear_err
);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t            state;
    logic [N_CH-1:0]   mask;
    logic [N_CH-1:0]   acc_mask;
    logic [CH_W-1:0]   idx;
    logic [CH_W-1:0]   enc_idx;
    logic              enc_found;
    logic [CNT_W-1:0]  cnt;
    logic              busy_sel;
    logic              hold;
    logic              tmo;
    state_t            adv;

    assign acc_mask   = cmd_bcast ? ch_enable : (N_CH'(1) << cmd_ch);
    assign busy_sel   = ch_busy[idx];
    assign tmo        = cnt == CNT_W'(TIMEOUT - 1);
    assign hold       = (state == WAIT_ACK) ? !busy_sel : busy_sel;
    assign adv        = (state == ISSUE) ? WAIT_ACK : (state == WAIT_ACK) ? WAIT_DONE : NEXT;
    assign cmd_ready  = state == IDLE;
    assign sched_busy = state != IDLE;
    assign done       = state == DONE;
    assign ch_start   = (state == ISSUE && !busy_sel) ? (N_CH'(1) << idx) : '0;

    // In IDLE the search runs over the incoming mask from bit 0; in NEXT it continues above idx.
    mic_cfg_prio_enc #(.N(N_CH), .W(CH_W)) u_enc (
        .mask       (state == IDLE ? acc_mask : mask),
        .base       (idx),
        .from_start (state == IDLE),
        .found      (enc_found),
        .idx        (enc_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mask        <= '0;
            idx         <= '0;
            cnt         <= '0;
            ch_addr     <= '0;
            ch_data     <= '0;
            err_timeout <= 1'b0;
            err_ch      <= '0;
        end else begin
            if (clear_err)
                err_timeout <= 1'b0;
            cnt <= '0;
            case (state)
                IDLE: if (cmd_valid) begin
                    ch_addr <= cmd_addr;
                    ch_data <= cmd_data;
                    mask    <= acc_mask;
                    idx     <= enc_idx;
                    state   <= enc_found ? ISSUE : DONE;
                end
                ISSUE, WAIT_ACK, WAIT_DONE: begin
                    if (!hold)
                        state <= adv;
                    else if (tmo) begin
                        err_timeout <= 1'b1;
                        err_ch      <= idx;
                        state       <= NEXT;
                    end else
                        cnt <= cnt + 1'b1;
                end
                NEXT: begin
                    mask[idx] <= 1'b0;
                    idx       <= enc_found ? enc_idx : idx;
                    state     <= enc_found ? ISSUE : DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
